// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID-stage hazard/flush control with a 2-entry writer scoreboard
// and a memory-wait freeze FSM with timeout.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 31,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idValid,
    input  logic [3:0]       idRn,
    input  logic [3:0]       idRdm,
    input  logic             idTwoSrc,
    input  logic             idWbEn,
    input  logic             idMemRead,
    input  logic [3:0]       idDest,
    input  logic             exBranch,
    input  logic             memReq,
    input  logic             memReady,
    output logic             hazard,
    output logic             flush,
    output logic             freeze,
    output logic             memErr,
    output logic [CNT_W-1:0] stallCount
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

    state_t        state;
    logic [TW-1:0] cnt;
    logic          exV, memV, exLd, memLd;
    logic [3:0]    exDest, memDest;
    logic          exMatch, memMatch;
    logic          unusedLd;

    // Load flag travels with each entry but no forwarding policy consumes it yet.
    assign unusedLd = memLd;

    always_comb begin
        exMatch  = exV & ((exDest == idRn) | (idTwoSrc & (exDest == idRdm)));
        memMatch = memV & ((memDest == idRn) | (idTwoSrc & (memDest == idRdm)));
        freeze   = (state == ERROR) | ((state == WAIT) & ~memReady)
                 | ((state == IDLE) & memReq & ~memReady);
        flush    = exBranch & ~freeze;
        hazard   = ~freeze & ~flush & idValid & (exMatch | memMatch);
        memErr   = state == ERROR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            exV        <= 1'b0;
            exDest     <= '0;
            exLd       <= 1'b0;
            memV       <= 1'b0;
            memDest    <= '0;
            memLd      <= 1'b0;
            stallCount <= '0;
        end else begin
            case (state)
                IDLE: if (memReq && !memReady) begin
                    state <= WAIT;
                    cnt   <= TW'(1);
                end
                WAIT: if (memReady) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (cnt == TW'(MEM_TIMEOUT)) begin
                    state <= ERROR;
                end else begin
                    cnt <= cnt + TW'(1);
                end
                ERROR: state <= ERROR;
                default: state <= IDLE;
            endcase
            // Flushed or stalled ID instructions enter EX as bubbles.
            if (!freeze) begin
                memV    <= exV;
                memDest <= exDest;
                memLd   <= exLd;
                exV     <= idValid & idWbEn & ~hazard & ~flush;
                exDest  <= idDest;
                exLd    <= idMemRead;
            end
            if ((hazard || freeze) && stallCount != '1)
                stallCount <= stallCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        idValid, idTwoSrc, idWbEn, idMemRead, exBranch, memReq, memReady;
    logic [3:0]  idRn, idRdm, idDest;
    logic        hazard, flush, freeze, memErr;
    logic [15:0] stallCount;
    int          tests = 0;
    int          failed = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(31), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .idValid(idValid), .idRn(idRn), .idRdm(idRdm),
        .idTwoSrc(idTwoSrc), .idWbEn(idWbEn), .idMemRead(idMemRead), .idDest(idDest),
        .exBranch(exBranch), .memReq(memReq), .memReady(memReady), .hazard(hazard),
        .flush(flush), .freeze(freeze), .memErr(memErr), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        idValid = 0; idTwoSrc = 0; idWbEn = 0; idMemRead = 0; exBranch = 0;
        memReq = 0; memReady = 0; idRn = 0; idRdm = 0; idDest = 0;
    endtask

    task automatic doReset();
        idle();
        rst = 0;
        #2;
        rst = 1;
    endtask

    task automatic issue(input logic [3:0] dest, input logic wb);
        idValid = 1; idWbEn = wb; idDest = dest; idRn = 0; idRdm = 0; idTwoSrc = 0;
    endtask

    initial begin
        idle();
        #12;
        chk("reset_hazard", hazard, 0);
        chk("reset_freeze", freeze, 0);
        chk("reset_memErr", memErr, 0);
        chk("reset_stall", stallCount, 0);
        rst = 1;

        // ADD r1 then SUB r2,r1,r3: RAW against EX, then MEM
        step(1);
        idValid = 1; idWbEn = 1; idDest = 1; idRn = 2; idRdm = 3; idTwoSrc = 1;
        #1 chk("add_no_hazard", hazard, 0);
        step(1);
        idRn = 1; idRdm = 3; idDest = 2;
        #1 chk("raw_ex", hazard, 1);
        step(1);
        #1 chk("raw_mem", hazard, 1);
        step(1);
        #1 chk("raw_clear", hazard, 0);
        chk("raw_stall", stallCount, 2);

        // invalid EX entry never matches
        doReset();
        step(1);
        issue(5, 0);
        step(1);
        idRn = 5; idDest = 0;
        #1 chk("invalid_entry", hazard, 0);
        chk("invalid_stall", stallCount, 0);

        // second source only counts when idTwoSrc
        doReset();
        step(1);
        issue(8, 1);
        step(1);
        idWbEn = 0; idRn = 0; idRdm = 8; idTwoSrc = 0;
        #1 chk("twosrc_off", hazard, 0);
        idTwoSrc = 1;
        #1 chk("twosrc_on", hazard, 1);
        idValid = 0;
        #1 chk("bubble_no_hazard", hazard, 0);

        // taken branch over a would-be hazard
        doReset();
        step(1);
        issue(4, 1);
        step(1);
        idRn = 4; idDest = 6; idWbEn = 1; exBranch = 1;
        #1 chk("branch_flush", flush, 1);
        chk("branch_hazard", hazard, 0);
        step(1);
        exBranch = 0; idRn = 6; idWbEn = 0; idDest = 0;
        #1 chk("flush_ex_invalid", hazard, 0);
        chk("flush_off", flush, 0);
        idRn = 4;
        #1 chk("flush_mem_kept", hazard, 1);
        chk("flush_stall", stallCount, 0);

        // memory wait of three cycles freezes the scoreboard
        doReset();
        step(1);
        issue(7, 1);
        step(1);
        idle();
        memReq = 1;
        #1 chk("wait_freeze0", freeze, 1);
        step(1);
        #1 chk("wait_freeze1", freeze, 1);
        step(1);
        idValid = 1; idRn = 7;
        #1 chk("wait_freeze2", freeze, 1);
        chk("freeze_masks_hazard", hazard, 0);
        step(1);
        memReady = 1;
        #1 chk("ready_unfreeze", freeze, 0);
        chk("sb_held", hazard, 1);
        chk("wait_stall", stallCount, 3);
        step(1);
        idle();
        #1 chk("back_idle", freeze, 0);
        chk("wait_stall2", stallCount, 4);
        memReq = 1; memReady = 1;
        #1 chk("single_cycle_access", freeze, 0);
        step(1);
        memReq = 0; memReady = 0;
        #1 chk("single_cycle_idle", freeze, 0);

        // timeout into ERROR
        doReset();
        memReq = 1;
        #1 chk("to_freeze", freeze, 1);
        step(31);
        #1 chk("to_wait31_memErr", memErr, 0);
        chk("to_wait31_freeze", freeze, 1);
        step(1);
        #1 chk("to_error_memErr", memErr, 1);
        memReq = 0; memReady = 1; exBranch = 1;
        #1 chk("error_freeze", freeze, 1);
        chk("error_flush", flush, 0);
        chk("error_stall", stallCount, 32);
        idle();
        rst = 0;
        #1 chk("err_rst_freeze", freeze, 0);
        chk("err_rst_memErr", memErr, 0);
        chk("err_rst_stall", stallCount, 0);
        chk("err_rst_hazard", hazard, 0);
        rst = 1;

        // reset in the middle of WAIT
        step(1);
        memReq = 1;
        step(3);
        memReq = 0;
        rst = 0;
        #1 chk("midwait_rst_freeze", freeze, 0);
        rst = 1;
        step(1);
        #1 chk("midwait_idle", freeze, 0);
        chk("midwait_stall", stallCount, 0);

        // saturation of stallCount under a permanent stall
        doReset();
        memReq = 1;
        step(65534);
        #1 chk("sat_fffe", stallCount, 16'hFFFE);
        step(1);
        #1 chk("sat_ffff", stallCount, 16'hFFFF);
        step(5);
        #1 chk("sat_hold", stallCount, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
